// File: rtl/accel_spi_pkg.sv
// Shared FSM encoding and ADXL362 burst-read constants for the accelerometer SPI reader.
package accel_spi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_SHIFT = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_DONE  = 3'd4;

  localparam logic [7:0] ADXL_CMD_READ     = 8'h0B;
  localparam logic [7:0] ADXL_ADDR_XDATA_L = 8'h0E;
  localparam int         FRAME_BITS        = 80;
  localparam int         RD_BYTES          = 8;
  localparam int         SAMPLE_W          = 12;

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: counts CLK_DIV cycles per half-period while enabled and
// toggles SCLK (mode 0, idle low) only when sclk_en is set.
module spi_sclk_gen #(
  parameter int CLK_DIV = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sclk_en,
  output logic half_tick,
  output logic rise_tick,
  output logic fall_tick,
  output logic sclk
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_reg;
  logic          sclk_reg;

  // Ticks flag the cycle whose closing edge moves SCLK.
  assign half_tick = en && (cnt_reg == CW'(CLK_DIV - 1));
  assign rise_tick = half_tick && sclk_en && !sclk_reg;
  assign fall_tick = half_tick && sclk_en && sclk_reg;
  assign sclk      = sclk_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg  <= '0;
      sclk_reg <= 1'b0;
    end else begin
      if (!en || half_tick) cnt_reg <= '0;
      else                  cnt_reg <= cnt_reg + 1'b1;
      if (!sclk_en)       sclk_reg <= 1'b0;
      else if (half_tick) sclk_reg <= ~sclk_reg;
    end
  end

endmodule

// File: rtl/accel_spi_reader.sv
// ADXL362 burst reader: one 80-bit SPI frame per start, X/Y/Z/T presented with a 1-cycle strobe.
// Optional free-running auto trigger when ACCEL_AUTO_SAMPLE_EN is defined.
module accel_spi_reader
  import accel_spi_pkg::*;
#(
  parameter int CLK_DIV       = 50,
  parameter int SAMPLE_PERIOD = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ACCEL_Start,
  output logic                o_SPI_SCLK,
  output logic                o_SPI_MOSI,
  input  logic                i_SPI_MISO,
  output logic                o_SPI_CSn,
  output logic [SAMPLE_W-1:0] o_ACCEL_X,
  output logic [SAMPLE_W-1:0] o_ACCEL_Y,
  output logic [SAMPLE_W-1:0] o_ACCEL_Z,
  output logic [SAMPLE_W-1:0] o_ACCEL_T,
  output logic                o_ACCEL_dataReady,
  output logic                o_ACCEL_Busy
);

  localparam int RX_W = RD_BYTES * 8;

  state_t                     state_reg, state_next;
  logic [6:0]                 bit_cnt_reg;
  logic [15:0]                tx_reg;
  logic [RX_W-1:0]            rx_reg;
  logic                       mosi_reg, cs_n_reg, busy_reg, ready_reg;
  logic [3:0][SAMPLE_W-1:0]   sample_word, sample_reg;
  logic                       half_tick, rise_tick, fall_tick;
  logic                       link_en, start_req, accept, frame_end;

  assign link_en   = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);
  assign accept    = (state_reg == ST_IDLE) && !busy_reg && start_req;
  assign frame_end = fall_tick && (bit_cnt_reg == 7'(FRAME_BITS - 1));

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .reset     (reset),
    .en        (link_en),
    .sclk_en   (state_reg == ST_SHIFT),
    .half_tick (half_tick),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .sclk      (o_SPI_SCLK)
  );

`ifdef ACCEL_AUTO_SAMPLE_EN
  logic [31:0] tmr_reg;
  logic        pending_reg, expire;

  assign expire    = (tmr_reg == 32'(SAMPLE_PERIOD - 1));
  assign start_req = i_ACCEL_Start || expire || pending_reg;

  // One expiry during a read is remembered; extra ones collapse into it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmr_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      tmr_reg <= expire ? '0 : tmr_reg + 1'b1;
      if (accept)                pending_reg <= 1'b0;
      else if (expire && busy_reg) pending_reg <= 1'b1;
    end
  end
`else
  assign start_req = i_ACCEL_Start;
  if (SAMPLE_PERIOD < 1) begin : g_sample_period_unused
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept)    state_next = ST_SETUP;
      ST_SETUP: if (half_tick) state_next = ST_SHIFT;
      ST_SHIFT: if (frame_end) state_next = ST_HOLD;
      ST_HOLD:  if (half_tick) state_next = ST_DONE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Read bytes arrive L,H per channel; only H[3:0] carries data.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_word
    localparam int L_MSB = RX_W - 1 - 16 * gi;
    assign sample_word[gi] = {rx_reg[L_MSB-12 -: 4], rx_reg[L_MSB -: 8]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      ready_reg   <= 1'b0;
      sample_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_reg == ST_DONE);
      cs_n_reg  <= !((state_next == ST_SETUP) || (state_next == ST_SHIFT) || (state_next == ST_HOLD));
      if (accept)         busy_reg <= 1'b1;
      else if (ready_reg) busy_reg <= 1'b0;
      // First command bit must already be on MOSI when CSn falls.
      if (accept) begin
        bit_cnt_reg <= '0;
        mosi_reg    <= ADXL_CMD_READ[7];
        tx_reg      <= {ADXL_CMD_READ[6:0], ADXL_ADDR_XDATA_L, 1'b0};
      end else if (fall_tick) begin
        mosi_reg <= tx_reg[15];
        tx_reg   <= {tx_reg[14:0], 1'b0};
        if (!frame_end) bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
      if (rise_tick) rx_reg <= {rx_reg[RX_W-2:0], i_SPI_MISO};
      if (state_reg == ST_DONE) sample_reg <= sample_word;
    end
  end

  assign o_SPI_MOSI        = mosi_reg;
  assign o_SPI_CSn         = cs_n_reg;
  assign o_ACCEL_X         = sample_reg[0];
  assign o_ACCEL_Y         = sample_reg[1];
  assign o_ACCEL_Z         = sample_reg[2];
  assign o_ACCEL_T         = sample_reg[3];
  assign o_ACCEL_dataReady = ready_reg;
  assign o_ACCEL_Busy      = busy_reg;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: ADXL362 slave model, scoreboard queue and a ready-strobe monitor.
module tb_accel_spi_reader;

  localparam int D   = 4;
  localparam int LAT = 162 * D + 1;

  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, miso = 1'b0;
  logic        sclk, mosi, csn, rdy, busy;
  logic [11:0] ax, ay, az, at;

  accel_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(500)) dut (
    .clk               (clk),
    .reset             (reset),
    .i_ACCEL_Start     (start),
    .o_SPI_SCLK        (sclk),
    .o_SPI_MOSI        (mosi),
    .i_SPI_MISO        (miso),
    .o_SPI_CSn         (csn),
    .o_ACCEL_X         (ax),
    .o_ACCEL_Y         (ay),
    .o_ACCEL_Z         (az),
    .o_ACCEL_T         (at),
    .o_ACCEL_dataReady (rdy),
    .o_ACCEL_Busy      (busy)
  );

  always #5 clk = ~clk;

  // exp_cyc: absolute ready cycle, -1 = two cycles after previous ready + LAT, -2 = unchecked
  typedef struct {
    logic [11:0] x, y, z, t;
    int          exp_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] slave_q[$];
  logic [63:0] shadow = '0;
  logic [15:0] cmd_bits = '0;
  int total = 0, bad = 0, cyc = 0;
  int rise_cnt = 0, fall_cnt = 0, frame_cnt = 0, ready_cnt = 0;
  int accept_cyc = 0, last_ready = 0;
  logic prev_rdy = 1'b0, prev_csn = 1'b1;

  always @(posedge clk) cyc++;

  // Reference: bytes XL,XH,YL,YH,ZL,ZH,TL,TH; value = (H mod 16)*256 + L.
  function automatic exp_t model(input logic [63:0] d, input int exp_cyc);
    exp_t r;
    int   by[8];
    for (int i = 0; i < 8; i++) by[i] = int'(d[63-8*i -: 8]);
    r.x = 12'((by[1] % 16) * 256 + by[0]);
    r.y = 12'((by[3] % 16) * 256 + by[2]);
    r.z = 12'((by[5] % 16) * 256 + by[4]);
    r.t = 12'((by[7] % 16) * 256 + by[6]);
    r.exp_cyc = exp_cyc;
    return r;
  endfunction

  // ADXL362 slave, SPI mode 0
  always @(negedge csn) begin
    if (slave_q.size() > 0) shadow = slave_q.pop_front();
    rise_cnt = 0; fall_cnt = 0; cmd_bits = '0; miso = 1'b0;
    frame_cnt++;
  end
  always @(posedge sclk) if (!csn) begin
    if (rise_cnt < 16) cmd_bits = {cmd_bits[14:0], mosi};
    rise_cnt++;
  end
  always @(negedge sclk) if (!csn) begin
    fall_cnt++;
    if (fall_cnt >= 16 && fall_cnt < 80) miso = shadow[63-(fall_cnt-16)];
    else miso = 1'b0;
  end

  always @(posedge csn) if (reset) begin
    total++;
    if (rise_cnt != 80) begin bad++; $display("FAIL sclk_rises: got %0d want 80", rise_cnt); end
    total++;
    if (cmd_bits !== 16'h0B0E) begin bad++; $display("FAIL mosi_cmd: got %h want 0b0e", cmd_bits); end
  end

  // Monitor: pops the scoreboard on every ready strobe
  always @(negedge clk) begin
    exp_t e;
    int   exp_c;
    if (!reset) begin
      prev_rdy = 1'b0; prev_csn = 1'b1;
    end else begin
      if (prev_rdy) begin
        total++;
        if (rdy !== 1'b0) begin bad++; $display("FAIL ready_width: ready=%b want 0", rdy); end
      end
      if (csn) begin
        total++;
        if (sclk !== 1'b0) begin bad++; $display("FAIL sclk_idle: sclk=%b want 0 with CSn high", sclk); end
      end
      if (!csn && prev_csn) accept_cyc = cyc;
      if (rdy) begin
        ready_cnt++;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_ready: busy=%b want 1", busy); end
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ready: ready at cycle %0d, want none", cyc);
        end else begin
          e = sb.pop_front();
          total++;
          if (ax !== e.x) begin bad++; $display("FAIL x: got %h want %h", ax, e.x); end
          total++;
          if (ay !== e.y) begin bad++; $display("FAIL y: got %h want %h", ay, e.y); end
          total++;
          if (az !== e.z) begin bad++; $display("FAIL z: got %h want %h", az, e.z); end
          total++;
          if (at !== e.t) begin bad++; $display("FAIL t: got %h want %h", at, e.t); end
          total++;
          if (cyc - accept_cyc != LAT) begin
            bad++; $display("FAIL latency: got %0d want %0d", cyc - accept_cyc, LAT);
          end
          if (e.exp_cyc != -2) begin
            exp_c = (e.exp_cyc == -1) ? last_ready + 2 + LAT : e.exp_cyc;
            total++;
            if (cyc != exp_c) begin bad++; $display("FAIL ready_cycle: got %0d want %0d", cyc, exp_c); end
          end
          $display("txn %0d: X=%03h Y=%03h Z=%03h T=%03h cycle=%0d", ready_cnt, ax, ay, az, at, cyc);
        end
        last_ready = cyc;
      end
      prev_rdy = rdy; prev_csn = csn;
    end
  end

  task automatic wait_ready(input int target, input int budget, input string tag);
    int n = 0;
    while (ready_cnt < target && n < budget) begin @(negedge clk); n++; end
    total++;
    if (ready_cnt < target) begin bad++; $display("FAIL %s_timeout: ready_count=%0d want %0d", tag, ready_cnt, target); end
  endtask

  task automatic wait_rise(input int target, input string tag);
    int n = 0;
    while (rise_cnt < target && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (rise_cnt < target) begin bad++; $display("FAIL %s_timeout: rises=%0d want %0d", tag, rise_cnt, target); end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rdy || !csn) && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic start_one(input logic [63:0] d);
    wait_idle();
    slave_q.push_back(d);
    sb.push_back(model(d, cyc + 1 + LAT));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({ax, ay, az, at, rdy, busy, csn, sclk, mosi} !== {48'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL %s: X=%h Y=%h Z=%h T=%h rdy=%b busy=%b csn=%b sclk=%b mosi=%b want zeros/csn=1",
               tag, ax, ay, az, at, rdy, busy, csn, sclk, mosi);
    end
  endtask

  initial begin
    int base, frames0;
    logic [63:0] d;
    #1 reset = 1'b0;
    #2 check_zero("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b1;
`ifdef ACCEL_AUTO_SAMPLE_EN
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      slave_q.push_back(d);
      sb.push_back(model(d, (i == 0) ? -2 : -1));
    end
    wait_ready(3, 3000, "auto");
`else
    // Directed sample from the datasheet-style example
    start_one(64'h3402FF0F00081001);
    wait_ready(1, 1000, "basic");

    // Start pulse mid-frame must be ignored
    frames0 = frame_cnt;
    start_one({$urandom, $urandom});
    wait_rise(30, "bit30");
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_ready(2, 1000, "ignore_start");
    repeat (700) @(negedge clk);
    total++;
    if (frame_cnt != frames0 + 1) begin bad++; $display("FAIL extra_frame: frames=%0d want %0d", frame_cnt - frames0, 1); end

    // Reset at bit 40 aborts the frame
    start_one({$urandom, $urandom});
    wait_rise(40, "bit40");
    @(negedge clk);
    #2 reset = 1'b0;
    sb.delete();
    #1 check_zero("abort_reset");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    base = ready_cnt;
    start_one({$urandom, $urandom});
    repeat (300) @(negedge clk);
    total++;
    if ({ax, ay, az, at} !== 48'h0) begin bad++; $display("FAIL post_reset_outputs: got %h want 0", {ax, ay, az, at}); end
    wait_ready(base + 1, 1000, "after_reset");

    // Start held high: three back-to-back frames
    wait_idle();
    base = ready_cnt;
    frames0 = frame_cnt;
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom};
      slave_q.push_back(d);
      sb.push_back(model(d, (i == 0) ? cyc + 1 + LAT : -1));
    end
    start = 1'b1;
    wait_ready(base + 3, 3000, "held_start");
    start = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (frame_cnt != frames0 + 3) begin bad++; $display("FAIL held_frames: frames=%0d want 3", frame_cnt - frames0); end

    // Randomised single reads with random idle gaps
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      base = ready_cnt;
      start_one({$urandom, $urandom});
      wait_ready(base + 1, 1000, "random");
    end
    repeat (5) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL scoreboard_left: entries=%0d want 0", sb.size()); end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
